// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle controller.
// Holds the FSM state encoding, opcode / funct / ALU-code constants,
// ALU B-source encodings, the FSM-to-decoder aluop codes and small
// helpers for the byte-fetch sequence.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH1  = 4'd0,
        FETCH2  = 4'd1,
        FETCH3  = 4'd2,
        FETCH4  = 4'd3,
        DECODE  = 4'd4,
        MEMADR  = 4'd5,
        LBRD    = 4'd6,
        LBWR    = 4'd7,
        SBWR    = 4'd8,
        RTYPEWR = 4'd9,
        ADDIWR  = 4'd10,
        BEQEX   = 4'd11,
        BEQTK   = 4'd12,
        JEX     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // Request from the FSM to the ALU decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Instruction-register byte lane written in each fetch state.
    function automatic logic [3:0] fetch_lane(input state_t s);
        logic [3:0] lane;
        case (s)
            FETCH1:  lane = 4'b0001;
            FETCH2:  lane = 4'b0010;
            FETCH3:  lane = 4'b0100;
            FETCH4:  lane = 4'b1000;
            default: lane = 4'b0000;
        endcase
        return lane;
    endfunction

    // Successor of each fetch state once its byte has arrived.
    function automatic state_t fetch_next(input state_t s);
        state_t nxt;
        case (s)
            FETCH1:  nxt = FETCH2;
            FETCH2:  nxt = FETCH3;
            FETCH3:  nxt = FETCH4;
            FETCH4:  nxt = DECODE;
            default: nxt = FETCH1;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// alu_decoder: combinational mapping from the FSM's aluop request and the
// R-type funct field to the 3-bit ALU operation code.
// Ports: aluop (in, 2)  - add / sub / use-funct request from the FSM
//        funct (in, 6)  - instr[5:0]
//        alucont (out, 3) - ALU operation
module alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucont
);

    // Select the ALU operation; unknown funct codes fall back to add.
    always_comb begin
        alucont = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucont = ALU_ADD;
            ALUOP_SUB: alucont = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucont = ALU_ADD;
                    FN_SUB:  alucont = ALU_SUB;
                    FN_AND:  alucont = ALU_AND;
                    FN_OR:   alucont = ALU_OR;
                    FN_SLT:  alucont = ALU_SLT;
                    default: alucont = ALU_ADD;
                endcase
            end
            default: alucont = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle control FSM for the 8-bit byte-fetch datapath.
// Fetches the instruction one byte per cycle (or skips to DECODE on an
// instruction-cache hit when CACHE_EN=1), decodes op/funct and drives every
// datapath select, enable and write strobe. Outputs are Mealy: a function of
// the state register plus op, funct, zero, hit and mem_ready.
// Ports: clk, reset_n (async active-low); op, funct (instruction fields);
//        zero, hit, mem_ready (status); memread, memwrite, iord, pcen,
//        alusrca, alusrcb, alucont, pcsource, irenable, irwrite, lord,
//        memtoreg, regdst, regwrite, add4pc (datapath controls);
//        illegal, instr_done (one-cycle event pulses).
module mc_controller
    import mc_pkg::*;
#(
    parameter bit CACHE_EN = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       hit,
    input  logic       mem_ready,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic       pcen,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucont,
    output logic       pcsource,
    output logic       irenable,
    output logic [3:0] irwrite,
    output logic       lord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       add4pc,
    output logic       illegal,
    output logic       instr_done
);

    state_t     state_r;
    state_t     next_s;
    logic [1:0] aluop_s;
    logic [2:0] alucont_s;
    logic       memread_s, memwrite_s, iord_s, pcen_s, alusrca_s;
    logic [1:0] alusrcb_s;
    logic       pcsource_s, irenable_s, lord_s, memtoreg_s, regdst_s;
    logic [3:0] irwrite_s;
    logic       regwrite_s, add4pc_s, illegal_s, instr_done_s;

    alu_decoder u_alu_decoder (
        .aluop   (aluop_s),
        .funct   (funct),
        .alucont (alucont_s)
    );

    // State register; reset drops straight back to the first fetch byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= FETCH1;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state and Mealy control decode for the current state.
    always_comb begin
        next_s       = state_r;
        aluop_s      = ALUOP_ADD;
        memread_s    = 1'b0;
        memwrite_s   = 1'b0;
        iord_s       = 1'b0;
        pcen_s       = 1'b0;
        alusrca_s    = 1'b0;
        alusrcb_s    = SRCB_RD2;
        pcsource_s   = 1'b0;
        irenable_s   = 1'b0;
        irwrite_s    = 4'b0000;
        lord_s       = 1'b0;
        memtoreg_s   = 1'b0;
        regdst_s     = 1'b0;
        regwrite_s   = 1'b0;
        add4pc_s     = 1'b0;
        illegal_s    = 1'b0;
        instr_done_s = 1'b0;
        case (state_r)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                memread_s = 1'b1;
                alusrcb_s = SRCB_ONE;
                // A cache hit outranks mem_ready: the whole word is
                // already available, so PC jumps by 4 and we decode.
                if (CACHE_EN && hit && (state_r == FETCH1)) begin
                    memread_s = 1'b0;
                    add4pc_s  = 1'b1;
                    pcen_s    = 1'b1;
                    next_s    = DECODE;
                end else if (mem_ready) begin
                    irenable_s = 1'b1;
                    irwrite_s  = fetch_lane(state_r);
                    pcen_s     = 1'b1;
                    next_s     = fetch_next(state_r);
                end else begin
                    next_s = state_r;
                end
            end
            DECODE: begin
                case (op)
                    OP_LB, OP_SB: next_s = MEMADR;
                    OP_RTYPE:     next_s = RTYPEWR;
                    OP_ADDI:      next_s = ADDIWR;
                    OP_BEQ:       next_s = BEQEX;
                    OP_J:         next_s = JEX;
                    default: begin
                        illegal_s    = 1'b1;
                        instr_done_s = 1'b1;
                        next_s       = FETCH1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = SRCB_IMM;
                if (op == OP_SB) begin
                    next_s = SBWR;
                end else begin
                    next_s = LBRD;
                end
            end
            LBRD: begin
                alusrca_s = 1'b1;
                alusrcb_s = SRCB_IMM;
                iord_s    = 1'b1;
                memread_s = 1'b1;
                lord_s    = mem_ready;
                if (mem_ready) begin
                    next_s = LBWR;
                end else begin
                    next_s = LBRD;
                end
            end
            LBWR: begin
                memtoreg_s   = 1'b1;
                regwrite_s   = 1'b1;
                instr_done_s = 1'b1;
                next_s       = FETCH1;
            end
            SBWR: begin
                alusrca_s  = 1'b1;
                alusrcb_s  = SRCB_IMM;
                iord_s     = 1'b1;
                memwrite_s = 1'b1;
                if (mem_ready) begin
                    instr_done_s = 1'b1;
                    next_s       = FETCH1;
                end else begin
                    next_s = SBWR;
                end
            end
            RTYPEWR: begin
                alusrca_s    = 1'b1;
                aluop_s      = ALUOP_FUNCT;
                regdst_s     = 1'b1;
                regwrite_s   = 1'b1;
                instr_done_s = 1'b1;
                next_s       = FETCH1;
            end
            ADDIWR: begin
                alusrca_s    = 1'b1;
                alusrcb_s    = SRCB_IMM;
                regwrite_s   = 1'b1;
                instr_done_s = 1'b1;
                next_s       = FETCH1;
            end
            BEQEX: begin
                alusrca_s = 1'b1;
                aluop_s   = ALUOP_SUB;
                next_s    = BEQTK;
            end
            BEQTK: begin
                alusrcb_s    = SRCB_IMMSH;
                pcen_s       = zero;
                instr_done_s = 1'b1;
                next_s       = FETCH1;
            end
            JEX: begin
                pcsource_s   = 1'b1;
                pcen_s       = 1'b1;
                instr_done_s = 1'b1;
                next_s       = FETCH1;
            end
            default: begin
                next_s = FETCH1;
            end
        endcase
    end

    // Output stage: reset forces a quiet, strobe-free PC+1 setup so nothing
    // can write while reset_n is low, even though FETCH1 itself would read.
    always_comb begin
        if (!reset_n) begin
            memread    = 1'b0;
            memwrite   = 1'b0;
            iord       = 1'b0;
            pcen       = 1'b0;
            alusrca    = 1'b0;
            alusrcb    = SRCB_ONE;
            alucont    = ALU_ADD;
            pcsource   = 1'b0;
            irenable   = 1'b0;
            irwrite    = 4'b0000;
            lord       = 1'b0;
            memtoreg   = 1'b0;
            regdst     = 1'b0;
            regwrite   = 1'b0;
            add4pc     = 1'b0;
            illegal    = 1'b0;
            instr_done = 1'b0;
        end else begin
            memread    = memread_s;
            memwrite   = memwrite_s;
            iord       = iord_s;
            pcen       = pcen_s;
            alusrca    = alusrca_s;
            alusrcb    = alusrcb_s;
            alucont    = alucont_s;
            pcsource   = pcsource_s;
            irenable   = irenable_s;
            irwrite    = irwrite_s;
            lord       = lord_s;
            memtoreg   = memtoreg_s;
            regdst     = regdst_s;
            regwrite   = regwrite_s;
            add4pc     = add4pc_s;
            illegal    = illegal_s;
            instr_done = instr_done_s;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed, scoreboard-based bench for mc_controller
// (built with CACHE_EN=1). Each cycle the expected output vector is pushed
// when the inputs are driven, then popped and compared at the falling edge.
module tb_mc_controller;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       pcen;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] alucont;
        logic       pcsource;
        logic       irenable;
        logic [3:0] irwrite;
        logic       lord;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       add4pc;
        logic       illegal;
        logic       instr_done;
    } out_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       hit;
    logic       mem_ready;
    logic       memread, memwrite, iord, pcen, alusrca, pcsource, irenable;
    logic [1:0] alusrcb;
    logic [2:0] alucont;
    logic [3:0] irwrite;
    logic       lord, memtoreg, regdst, regwrite, add4pc, illegal, instr_done;

    out_t obs;
    out_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    assign obs = {memread, memwrite, iord, pcen, alusrca, alusrcb, alucont,
                  pcsource, irenable, irwrite, lord, memtoreg, regdst,
                  regwrite, add4pc, illegal, instr_done};

    mc_controller #(.CACHE_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
        .hit(hit), .mem_ready(mem_ready), .memread(memread),
        .memwrite(memwrite), .iord(iord), .pcen(pcen), .alusrca(alusrca),
        .alusrcb(alusrcb), .alucont(alucont), .pcsource(pcsource),
        .irenable(irenable), .irwrite(irwrite), .lord(lord),
        .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
        .add4pc(add4pc), .illegal(illegal), .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    // Idle defaults: everything low, ALU B = rd2, ALU op = add.
    function automatic out_t base();
        out_t e;
        e = '0;
        e.alucont = 3'b010;
        return e;
    endfunction

    function automatic out_t exp_reset();
        out_t e;
        e = base();
        e.alusrcb = 2'b01;
        return e;
    endfunction

    function automatic out_t exp_fetch(input int n, input logic rdy);
        out_t e;
        e = base();
        e.memread = 1'b1;
        e.alusrcb = 2'b01;
        if (rdy) begin
            e.irenable = 1'b1;
            e.pcen     = 1'b1;
            e.irwrite  = 4'(4'b0001 << (n - 1));
        end
        return e;
    endfunction

    // ALU selects shared by MEMADR / LBRD / SBWR: rd1 + imm.
    function automatic out_t exp_memadr();
        out_t e;
        e = base();
        e.alusrca = 1'b1;
        e.alusrcb = 2'b10;
        return e;
    endfunction

    // Push expectation, compare at the falling edge, then move to just after
    // the next rising edge where the following inputs get driven.
    task automatic step(input string tag, input out_t e);
        out_t want;
        exp_q.push_back(e);
        @(negedge clk);
        want = exp_q.pop_front();
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch4();
        mem_ready = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            step($sformatf("fetch%0d", n), exp_fetch(n, 1'b1));
        end
    endtask

    logic [5:0] fn_tab [5] = '{6'b100000, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    logic [2:0] ac_tab [5] = '{3'b010, 3'b000, 3'b001, 3'b111, 3'b010};

    initial begin
        out_t e;
        reset_n = 1'b0; op = 6'b000000; funct = 6'b000000;
        zero = 1'b0; hit = 1'b0; mem_ready = 1'b1;
        step("reset", exp_reset());
        reset_n = 1'b1;

        // RTYPE sub, mem_ready tied high: 6 cycles.
        op = 6'b000000; funct = 6'b100010;
        fetch4();
        step("rt_decode", base());
        e = base(); e.alusrca = 1'b1; e.alucont = 3'b110; e.regdst = 1'b1;
        e.regwrite = 1'b1; e.instr_done = 1'b1;
        step("rt_sub_wr", e);

        // Remaining funct codes including an unknown one (falls back to add).
        for (int i = 0; i < 5; i++) begin
            funct = fn_tab[i];
            fetch4();
            step("rt_decode", base());
            e = base(); e.alusrca = 1'b1; e.alucont = ac_tab[i]; e.regdst = 1'b1;
            e.regwrite = 1'b1; e.instr_done = 1'b1;
            step($sformatf("rt_wr_fn%0d", i), e);
        end

        // ADDI: 6 cycles.
        op = 6'b001000; funct = 6'b100010;
        fetch4();
        step("addi_decode", base());
        e = exp_memadr(); e.regwrite = 1'b1; e.instr_done = 1'b1;
        step("addi_wr", e);

        // LB with 3 stalls in FETCH2 and 2 in LBRD: 13 cycles.
        op = 6'b100000;
        mem_ready = 1'b1; step("lb_f1", exp_fetch(1, 1'b1));
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("lb_f2_stall", exp_fetch(2, 1'b0));
        mem_ready = 1'b1;
        step("lb_f2", exp_fetch(2, 1'b1));
        step("lb_f3", exp_fetch(3, 1'b1));
        step("lb_f4", exp_fetch(4, 1'b1));
        step("lb_decode", base());
        step("lb_memadr", exp_memadr());
        mem_ready = 1'b0;
        e = exp_memadr(); e.iord = 1'b1; e.memread = 1'b1;
        for (int i = 0; i < 2; i++) step("lb_rd_stall", e);
        mem_ready = 1'b1;
        e.lord = 1'b1;
        step("lb_rd", e);
        e = base(); e.memtoreg = 1'b1; e.regwrite = 1'b1; e.instr_done = 1'b1;
        step("lb_wr", e);

        // SB with one stall in SBWR.
        op = 6'b101000;
        fetch4();
        step("sb_decode", base());
        step("sb_memadr", exp_memadr());
        mem_ready = 1'b0;
        e = exp_memadr(); e.iord = 1'b1; e.memwrite = 1'b1;
        step("sb_wr_stall", e);
        mem_ready = 1'b1;
        e.instr_done = 1'b1;
        step("sb_wr", e);

        // BEQ taken then not taken: 7 cycles each.
        op = 6'b000100;
        for (int t = 1; t >= 0; t--) begin
            zero = t[0];
            fetch4();
            step("beq_decode", base());
            e = base(); e.alusrca = 1'b1; e.alucont = 3'b110;
            step("beq_ex", e);
            e = base(); e.alusrcb = 2'b11; e.pcen = t[0]; e.instr_done = 1'b1;
            step($sformatf("beq_tk_z%0d", t), e);
        end
        zero = 1'b0;

        // J via cache hit (hit outranks a stalled memory): 3 cycles.
        op = 6'b000010; hit = 1'b1; mem_ready = 1'b0;
        e = base(); e.alusrcb = 2'b01; e.add4pc = 1'b1; e.pcen = 1'b1;
        step("j_hit_f1", e);
        hit = 1'b0;
        step("j_decode", base());
        e = base(); e.pcsource = 1'b1; e.pcen = 1'b1; e.instr_done = 1'b1;
        step("j_ex", e);

        // J without hit: 6 cycles.
        fetch4();
        step("j2_decode", base());
        step("j2_ex", e);

        // Illegal opcode: pulse in DECODE, then back to FETCH1.
        op = 6'b111111;
        fetch4();
        e = base(); e.illegal = 1'b1; e.instr_done = 1'b1;
        step("ill_decode", e);
        mem_ready = 1'b0;
        step("ill_f1_next", exp_fetch(1, 1'b0));

        // Reset mid-LBRD: abandoned, no strobes, fetch restarts at FETCH1.
        op = 6'b100000;
        fetch4();
        step("rlb_decode", base());
        step("rlb_memadr", exp_memadr());
        mem_ready = 1'b0;
        e = exp_memadr(); e.iord = 1'b1; e.memread = 1'b1;
        step("rlb_rd_stall", e);
        mem_ready = 1'b1; reset_n = 1'b0;
        step("rlb_in_reset", exp_reset());
        reset_n = 1'b1; mem_ready = 1'b0;
        step("rlb_after_f1", exp_fetch(1, 1'b0));
        mem_ready = 1'b1;
        step("rlb_after_f1_rdy", exp_fetch(1, 1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control FSM that sequences the 8-bit byte-fetch datapath (register file, ALU, 4-byte instruction register, instruction cache) for one core.
- Decodes op/funct and drives every datapath select, enable and write strobe.
- Also drives the external PC register enable and the memory address-source select.
- Stalls on a memory ready handshake.
- One instance per core; both cores use identical controllers.

Parameters:
- CACHE_EN, 0, 1 enables the one-cycle fetch bypass on an instruction-cache hit.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- op  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- zero  in  1  registered ALU-zero flag from the datapath
- hit  in  1  instruction-cache hit for the current pc
- mem_ready  in  1  memory completes the current read/write this cycle
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- iord  out  1  memory address select: 0 = pc, 1 = aluout
- pcen  out  1  PC register load enable
- alusrca  out  1  ALU A select: 0 = pc, 1 = rd1
- alusrcb  out  2  ALU B select: 00 = rd2, 01 = 1, 10 = imm, 11 = imm<<2
- alucont  out  3  ALU operation
- pcsource  out  1  PC source select: 0 = aluout, 1 = jump address
- irenable  out  1  instruction register write enable
- irwrite  out  4  one-hot instruction-register byte lane
- lord  out  1  latch memdata into the memory data register
- memtoreg  out  1  write-back select: 1 = memory data register, 0 = aluout
- regdst  out  1  destination register select: 1 = rd field, 0 = rt field
- regwrite  out  1  register file write enable
- add4pc  out  1  cache-hit PC+4 request
- illegal  out  1  one-cycle pulse on an unknown opcode
- instr_done  out  1  one-cycle pulse on the final state of each instruction

Behaviour:
- Reset: state = FETCH1 immediately on reset_n low. While in reset every output is 0 except alusrcb = 01 and alucont = 010 (add).
- Defaults: in every state, any output not listed for that state is 0, with alusrcb = 00 and alucont = 010.
- Opcodes: RTYPE 000000, LB 100000, SB 101000, BEQ 000100, J 000010, ADDI 001000.
- ALU codes: add 010, sub 110, and 000, or 001, slt 111.
- Funct decode (RTYPE only): 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other funct gives add.
- FETCHn (n = 1..4): memread = 1, iord = 0, alusrca = 0, alusrcb = 01, add, pcsource = 0.
  - While mem_ready = 0: hold the state; irenable = 0, pcen = 0.
  - When mem_ready = 1: irenable = 1, irwrite = one-hot bit n-1, pcen = 1.
  - FETCH1 to FETCH2 to FETCH3 to FETCH4 to DECODE. PC therefore advances by 1 per byte.
- FETCH1 cache bypass: when CACHE_EN = 1 and hit = 1, hit takes priority over mem_ready.
  - memread = 0, add4pc = 1, pcen = 1, next = DECODE.
- DECODE: no strobes. Next state by op:
  - LB or SB: MEMADR
  - RTYPE: RTYPEWR
  - ADDI: ADDIWR
  - BEQ: BEQEX
  - J: JEX
  - Any other op: illegal = 1, instr_done = 1, next = FETCH1.
- MEMADR: alusrca = 1, alusrcb = 10, add. Next = LBRD for LB, SBWR for SB.
- LBRD: same ALU selects as MEMADR, iord = 1, memread = 1.
  - lord = mem_ready; hold the state until mem_ready = 1, then go to LBWR.
- LBWR: memtoreg = 1, regdst = 0, regwrite = 1, instr_done = 1. Next = FETCH1.
- SBWR: same ALU selects as MEMADR, iord = 1, memwrite = 1.
  - Hold until mem_ready = 1; then instr_done = 1, next = FETCH1.
- RTYPEWR: alusrca = 1, alusrcb = 00, alucont from funct, regdst = 1, regwrite = 1, instr_done = 1. Next = FETCH1.
- ADDIWR: alusrca = 1, alusrcb = 10, add, regdst = 0, regwrite = 1, instr_done = 1. Next = FETCH1.
- BEQEX: alusrca = 1, alusrcb = 00, sub. The datapath registers zero at this edge. Next = BEQTK.
- BEQTK: alusrca = 0, alusrcb = 11, add, pcsource = 0, pcen = zero, instr_done = 1. Next = FETCH1.
- JEX: pcsource = 1, pcen = 1, instr_done = 1. Next = FETCH1.
- Latencies with mem_ready tied to 1, including the 4 fetch cycles:
  - RTYPE and ADDI: 6 cycles
  - J: 6 cycles
  - BEQ: 7 cycles
  - SB: 7 cycles
  - LB: 8 cycles
  - With a cache hit, subtract 3.
- Reset asserted mid-instruction abandons it; no write strobe may be asserted during or after the reset assertion.
- Outputs are pure functions of state plus op, funct, zero, hit and mem_ready (Mealy). No output may glitch a write strobe outside its stated condition.

Decomposition:
- Package mc_pkg:
  - state enum: FETCH1–4, DECODE, MEMADR, LBRD, LBWR, SBWR, RTYPEWR, ADDIWR, BEQEX, BEQTK, JEX
  - opcode constants
  - funct constants
  - ALU-code constants
  - alusrcb encodings
- Sub-module alu_decoder: combinational funct-to-alucont mapping, selected by an aluop from the FSM.

Test Plan:
- Reset mid-LBRD (reset_n low for 1 cycle) -> state FETCH1; regwrite, memwrite and lord never asserted; memread = 1 after release.
- RTYPE funct 100010, mem_ready = 1 -> irwrite 0001, 0010, 0100, 1000 on cycles 1–4; pcen for 4 cycles; cycle 6 has regwrite = 1, regdst = 1, alucont = 110, instr_done = 1.
- LB with mem_ready low for 3 cycles in FETCH2 and 2 cycles in LBRD -> FETCH2 held with irenable = 0 and pcen = 0; lord pulses exactly once; total 13 cycles; LBWR has memtoreg = 1.
- BEQ with zero = 1, then zero = 0 -> BEQTK pcen = 1 then pcen = 0; alusrcb = 11 both times; 7 cycles each.
- CACHE_EN = 1, hit = 1 in FETCH1 with J -> add4pc = 1, memread = 0, DECODE next cycle; JEX has pcsource = 1; 3 cycles total.
- op 111111 -> illegal and instr_done pulse once in DECODE; no write strobes; FETCH1 follows.
